// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Pipeline hazard controller. It keeps a three-entry shift register holding
//   the destination registers of the instructions in EX, MEM and WB. From
//   these entries and the operands of the instruction in ID it produces:
//     - a load-use stall: one bubble into EX, with the PC and IF/ID held;
//     - operand forwarding selects for the ID/EX operand muxes.
//
// Parameters:
//   REG_W   width of a register specifier
//   PC_REG  register index that is never stalled on or forwarded (the PC)
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   id_rn/rm       ID source operand A / B register
//   id_rd_src      ID store-data source register
//   id_*_used      the matching source is actually read by the ID instruction
//   id_dest        ID destination register
//   id_rf_enable   ID instruction writes the register file
//   id_load_instr  ID instruction is a load
//   nop_signal     1 = zero the ID control word (bubble into EX)
//   pc_le          PC load enable
//   ifid_le        IF/ID register load enable
//   fwd_a/b/c      select: 00 reg file, 01 EX, 10 MEM, 11 WB
//   stall_count    (only with HAZARD_STATS_EN) saturating count of bubbles
//
// Build option:
//   HAZARD_STATS_EN  adds the 16-bit stall_count output and its counter.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd_src,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             id_rd_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  output logic             nop_signal,
  output logic             pc_le,
  output logic             ifid_le,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  // Tracker entries. Only the EX entry keeps its load flag: once a load has
  // left EX its data is forwardable, so MEM and WB never consult it.
  logic             ex_vld_q, mem_vld_q, wb_vld_q;
  logic [REG_W-1:0] ex_dest_q, mem_dest_q, wb_dest_q;
  logic             ex_ld_q;

  logic             ex_vld_d, ex_ld_d;
  logic             load_use;

  function automatic logic hit(input logic             vld,
                               input logic [REG_W-1:0] dest,
                               input logic [REG_W-1:0] src,
                               input logic             used);
    return vld & (dest == src) & (src != PC_IDX) & used;
  endfunction

  // Priority EX > MEM > WB. A load sitting in EX cannot supply its data yet,
  // so it is skipped here; the stall logic covers that case.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             used);
    logic [1:0] sel;
    sel = 2'b00;
    if (hit(ex_vld_q, ex_dest_q, src, used) && !ex_ld_q) begin
      sel = 2'b01;
    end else if (hit(mem_vld_q, mem_dest_q, src, used)) begin
      sel = 2'b10;
    end else if (hit(wb_vld_q, wb_dest_q, src, used)) begin
      sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_ld_q & (hit(ex_vld_q, ex_dest_q, id_rn,     id_rn_used) |
                          hit(ex_vld_q, ex_dest_q, id_rm,     id_rm_used) |
                          hit(ex_vld_q, ex_dest_q, id_rd_src, id_rd_used));

    nop_signal = reset | load_use;
    pc_le      = ~nop_signal;
    ifid_le    = ~nop_signal;

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    fwd_c = 2'b00;
    if (!reset) begin
      fwd_a = fwd_sel(id_rn,     id_rn_used);
      fwd_b = fwd_sel(id_rm,     id_rm_used);
      fwd_c = fwd_sel(id_rd_src, id_rd_used);
    end

    // A bubble enters EX with its write and load flags cleared.
    ex_vld_d = id_rf_enable  & ~nop_signal;
    ex_ld_d  = id_load_instr & ~nop_signal;
  end

  // ---- ID -> EX -> MEM -> WB tracker: control bits (reset) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_vld_q  <= 1'b0;
      mem_vld_q <= 1'b0;
      wb_vld_q  <= 1'b0;
      ex_ld_q   <= 1'b0;
    end else begin
      wb_vld_q  <= mem_vld_q;
      mem_vld_q <= ex_vld_q;
      ex_vld_q  <= ex_vld_d;
      ex_ld_q   <= ex_ld_d;
    end
  end

  // ---- ID -> EX -> MEM -> WB tracker: register specifiers (no reset) ----
  always_ff @(posedge clk) begin
    wb_dest_q  <= mem_dest_q;
    mem_dest_q <= ex_dest_q;
    ex_dest_q  <= id_dest;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  localparam int REG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] id_rn, id_rm, id_rd_src, id_dest;
  logic             id_rn_used, id_rm_used, id_rd_used, id_rf_enable, id_load_instr;
  logic             nop_signal, pc_le, ifid_le;
  logic [1:0]       fwd_a, fwd_b, fwd_c;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_count;
`endif

  hazard_forward_unit #(.REG_W(REG_W), .PC_REG(15)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd_src(id_rd_src),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd_used(id_rd_used),
    .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
    .nop_signal(nop_signal), .pc_le(pc_le), .ifid_le(ifid_le),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  bit               m_vld [3];
  logic [REG_W-1:0] m_dest[3];
  bit               m_ld  [3];
  int               m_cnt;

  logic       e_haz, e_nop;
  logic [1:0] e_fa, e_fb, e_fc;

  function automatic bit uses(input int s, input logic [REG_W-1:0] r, input logic used);
    return used && (r != 4'd15) && m_vld[s] && (m_dest[s] == r);
  endfunction

  // Oldest first so that the youngest matching stage overwrites the choice.
  function automatic logic [1:0] ref_sel(input logic [REG_W-1:0] r, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    for (int s = 2; s >= 0; s--)
      if (uses(s, r, used) && !(s == 0 && m_ld[0])) sel = 2'(s + 1);
    return sel;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic setid(input logic [3:0] rn, input logic rnu, input logic [3:0] rm,
                       input logic rmu, input logic [3:0] rd, input logic rdu,
                       input logic [3:0] dest, input logic rfen, input logic ld);
    id_rn = rn; id_rn_used = rnu; id_rm = rm; id_rm_used = rmu;
    id_rd_src = rd; id_rd_used = rdu; id_dest = dest;
    id_rf_enable = rfen; id_load_instr = ld;
  endtask

  task automatic sample();
    @(negedge clk);
    e_haz = !reset && m_ld[0] && (uses(0, id_rn, id_rn_used) ||
                                  uses(0, id_rm, id_rm_used) ||
                                  uses(0, id_rd_src, id_rd_used));
    e_nop = reset || e_haz;
    e_fa  = reset ? 2'b00 : ref_sel(id_rn, id_rn_used);
    e_fb  = reset ? 2'b00 : ref_sel(id_rm, id_rm_used);
    e_fc  = reset ? 2'b00 : ref_sel(id_rd_src, id_rd_used);
    chk("nop_signal", 16'(nop_signal), 16'(e_nop));
    chk("pc_le",      16'(pc_le),      16'(!e_nop));
    chk("ifid_le",    16'(ifid_le),    16'(!e_nop));
    chk("fwd_a",      16'(fwd_a),      16'(e_fa));
    chk("fwd_b",      16'(fwd_b),      16'(e_fb));
    chk("fwd_c",      16'(fwd_c),      16'(e_fc));
`ifdef HAZARD_STATS_EN
    chk("stall_count", stall_count, 16'(m_cnt));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      for (int s = 0; s < 3; s++) begin m_vld[s] = 0; m_ld[s] = 0; end
      m_cnt = 0;
    end else begin
      for (int s = 2; s > 0; s--) begin
        m_vld[s] = m_vld[s-1]; m_dest[s] = m_dest[s-1]; m_ld[s] = m_ld[s-1];
      end
      m_vld[0]  = id_rf_enable && !e_nop;
      m_dest[0] = id_dest;
      m_ld[0]   = id_load_instr && !e_nop;
      if (e_haz && m_cnt != 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic logic [3:0] rand_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 4'd15 : 4'(k + 1);
  endfunction

  initial begin
    for (int s = 0; s < 3; s++) begin m_vld[s] = 0; m_ld[s] = 0; m_dest[s] = '0; end
    m_cnt = 0;

    // Reset held three cycles with arbitrary ID inputs.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setid(4'(i + 1), 1, 4'(i + 1), 1, 4'(i + 1), 1, 4'(i + 1), 1, 1);
      sample();
      chk("rst_nop", 16'(nop_signal), 16'd1);
      chk("rst_pc_le", 16'(pc_le), 16'd0);
      chk("rst_fwd", 16'({fwd_a, fwd_b, fwd_c}), 16'd0);
      advance();
    end
    reset = 1'b0;

    // ADD r1, then readers of r1 at distances 1..4.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0);
    sample();
    chk("post_rst_nop", 16'(nop_signal), 16'd0);
    chk("post_rst_fwd", 16'({fwd_a, fwd_b, fwd_c}), 16'd0);
    advance();
    setid(4'd1, 1, 4'd0, 0, 4'd0, 0, 4'd6, 0, 0);
    sample(); chk("fwd_ex",  16'(fwd_a), 16'd1); chk("fwd_ex_nop", 16'(nop_signal), 16'd0); advance();
    sample(); chk("fwd_mem", 16'(fwd_a), 16'd2); advance();
    sample(); chk("fwd_wb",  16'(fwd_a), 16'd3); advance();
    sample(); chk("fwd_rf",  16'(fwd_a), 16'd0); advance();

    // LDR r2, then ADD using rm=r2: one bubble, then MEM forwarding.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);
    step();
    setid(4'd0, 0, 4'd2, 1, 4'd0, 0, 4'd7, 1, 0);
    sample();
    chk("lu_nop", 16'(nop_signal), 16'd1);
    chk("lu_pc_le", 16'(pc_le), 16'd0);
    chk("lu_ifid_le", 16'(ifid_le), 16'd0);
    advance();
    sample();
    chk("lu_after_nop", 16'(nop_signal), 16'd0);
    chk("lu_after_fwd_b", 16'(fwd_b), 16'd2);
    advance();

    // r3 written by WB, MEM and EX; EX must win on all three selects.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0);
    step(); step(); step();
    setid(4'd3, 1, 4'd3, 1, 4'd3, 1, 4'd8, 0, 0);
    sample(); chk("youngest_wins", 16'({fwd_a, fwd_b, fwd_c}), 16'b010101); advance();

    // PC register is never forwarded or stalled on, even from a load.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd15, 1, 1);
    step();
    setid(4'd15, 1, 4'd15, 1, 4'd0, 0, 4'd8, 0, 0);
    sample();
    chk("pc_fwd_a", 16'(fwd_a), 16'd0);
    chk("pc_nostall", 16'(nop_signal), 16'd0);
    advance();

    // Load that does not write the register file causes no stall.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd4, 0, 1);
    step();
    setid(4'd4, 1, 4'd0, 0, 4'd0, 0, 4'd8, 0, 0);
    sample(); chk("ld_norf_nostall", 16'(nop_signal), 16'd0); advance();

    // Reset in the middle of a stall leaves no residual bubble.
    setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1);
    step();
    setid(4'd0, 0, 4'd0, 0, 4'd5, 1, 4'd9, 1, 0);
    sample(); chk("mid_stall_nop", 16'(nop_signal), 16'd1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    sample();
    chk("mid_rst_nop", 16'(nop_signal), 16'd0);
    chk("mid_rst_fwd_c", 16'(fwd_c), 16'd0);
    advance();

`ifdef HAZARD_STATS_EN
    reset = 1'b1; step(); reset = 1'b0;
    for (int h = 0; h < 5; h++) begin
      setid(4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);
      step();
      setid(4'd2, 1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0);
      step(); step();
    end
    sample(); chk("stats_five", stall_count, 16'd5); advance();
    reset = 1'b1; step(); reset = 1'b0;
    sample(); chk("stats_cleared", stall_count, 16'd0); advance();
`endif

    // Randomised traffic over a small register set to provoke many matches.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      setid(rand_reg(), 1'($urandom), rand_reg(), 1'($urandom), rand_reg(), 1'($urandom),
            rand_reg(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
